// File: rtl/display_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller.
package display_pkg;

    // Scan FSM encoding
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    // One-hot digit selects
    localparam logic [3:0] DIG0 = 4'b0001;
    localparam logic [3:0] DIG1 = 4'b0010;
    localparam logic [3:0] DIG2 = 4'b0100;
    localparam logic [3:0] DIG3 = 4'b1000;

    // Board clock defaults: cycles per digit slot and dark cycles at slot start
    localparam int TICK_DIV_DEF  = 65536;
    localparam int BLANK_CYC_DEF = 16;

    // Rotate a 4-bit one-hot value left by k (0..4) positions
    function automatic logic [3:0] rotl4(input logic [3:0] v, input int k);
        logic [7:0] w;
        w = {v, v} << k;
        return w[7:4];
    endfunction

endpackage

// File: rtl/scan_next_digit.sv
// Finds the next enabled digit in rotation order 0->1->2->3->0.
// With incl_cur_i the current digit is a candidate; otherwise the search
// starts one place further and wraps back onto the current digit last.
module scan_next_digit
    import display_pkg::*;
(
    input  logic [3:0] sel_i,
    input  logic [3:0] digit_en_i,
    input  logic       incl_cur_i,
    output logic [3:0] next_o
);

    logic [3:0] cand;

    // Walk rotations from farthest to nearest so the nearest enabled digit wins;
    // with nothing enabled the current select is kept so it stays one-hot.
    always_comb begin
        next_o = sel_i;
        cand   = '0;
        for (int k = 4; k >= 0; k--) begin
            cand = rotl4(sel_i, k);
            if (((k > 0) || incl_cur_i) && (|(cand & digit_en_i))) begin
                next_o = cand;
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexing scan controller for the 4-digit 7-segment display.
// Each digit slot is TICK_DIV cycles: BLANK_CYC dark, then the digit lit.
// All outputs are registered from the next-state values so they line up
// with the state they describe.
//
// state    | meaning
// ST_OFF   | display dark, counter parked at 0, sel held
// ST_BLANK | anodes off at slot start while selector/segments settle
// ST_SHOW  | selected digit lit; slot end advances sel and pulses scan_tick
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF,
    parameter int CNT_W     = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_en,
    input  logic [3:0] dp_in,
    output logic [3:0] sel,
    output logic [3:0] an,
    output logic       dp,
    output logic       scan_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;
    logic [3:0]       nxt_sel;
    logic             scan_ok;

    assign scan_ok = en && (digit_en != 4'b0000);

    // Leaving OFF may re-use the current digit; a slot advance must move on.
    scan_next_digit u_next (
        .sel_i      (sel_q),
        .digit_en_i (digit_en),
        .incl_cur_i (state_q == ST_OFF),
        .next_o     (nxt_sel)
    );

    // State, counter and registered outputs with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            sel_q   <= DIG0;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    // Next state, slot counter and digit rotation; global disable wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (!scan_ok) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    sel_d   = nxt_sel;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_BLANK_END) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        sel_d   = nxt_sel;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        an_d   = 4'b1111;
        dp_d   = 1'b1;
        tick_d = 1'b0;
        if (state_d == ST_SHOW) begin
            an_d   = ~(sel_d & digit_en);
            dp_d   = ~(|(sel_d & dp_in));
            tick_d = (cnt_d == CNT_LAST);
        end
    end

    assign sel       = sel_q;
    assign an        = an_q;
    assign dp        = dp_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with a slot-level reference model.
module tb_display_scan_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [3:0] digit_en = 4'b0000;
    logic [3:0] dp_in = 4'b0000;
    logic [3:0] sel;
    logic [3:0] an;
    logic       dp;
    logic       scan_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: is the display running, position within the slot, digit index
    bit m_active = 0;
    int m_phase  = 0;
    int m_cur    = 0;

    display_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .sel       (sel),
        .an        (an),
        .dp        (dp),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_digit(input int c, input logic [3:0] de, input int start);
        for (int k = start; k <= 4; k++) begin
            if (de[(c + k) % 4]) return (c + k) % 4;
        end
        return c;
    endfunction

    function automatic void model_edge();
        if (!en || digit_en == 4'b0000) begin
            m_active = 0;
            m_phase  = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_phase  = 0;
            m_cur    = find_digit(m_cur, digit_en, 0);
        end else if (m_phase == TD - 1) begin
            m_phase = 0;
            m_cur   = find_digit(m_cur, digit_en, 1);
        end else begin
            m_phase++;
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic [3:0] e_an;
        logic       e_dp;
        logic       e_tick;
        bit         lit;
        lit    = m_active && (m_phase >= BC);
        e_an   = 4'b1111;
        e_dp   = 1'b1;
        e_tick = 1'b0;
        if (lit) begin
            e_an[m_cur] = ~digit_en[m_cur];
            e_dp        = ~dp_in[m_cur];
            e_tick      = (m_phase == TD - 1);
        end
        chk({tag, ".sel"}, 32'(sel), 32'(4'b0001 << m_cur));
        chk({tag, ".an"}, 32'(an), 32'(e_an));
        chk({tag, ".dp"}, 32'(dp), 32'(e_dp));
        chk({tag, ".tick"}, 32'(scan_tick), 32'(e_tick));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        m_active = 0;
        m_phase  = 0;
        m_cur    = 0;
        check_outputs(tag);
        #1 rst_n = 1'b1;
    endtask

    // Advance until the model is on the given SHOW phase of a digit, bounded
    task automatic run_until(input string tag, input int digit, input int phase);
        int budget = 100;
        while (!(m_active && m_cur == digit && m_phase == phase) && budget > 0) begin
            step(tag);
            budget--;
        end
        chk({tag, ".timeout"}, 32'(budget == 0), 32'd0);
    endtask

    int tick_cnt;

    initial begin
        #2 rst_n = 1'b0;
        #1 check_outputs("rst_async");
        #1 rst_n = 1'b1;
        run("rst_hold", 5);

        en = 1'b1; digit_en = 4'b1111; dp_in = 4'b0010;
        tick_cnt = 0;
        for (int i = 0; i < 41; i++) begin
            step("all4");
            if (scan_tick) tick_cnt++;
        end
        chk("all4.ticks", 32'(tick_cnt), 32'd5);

        digit_en = 4'b0101;
        run("d0101", 34);

        digit_en = 4'b1111;
        run_until("seek2", 2, BC + 3);
        en = 1'b0;
        run("en_drop", 3);
        en = 1'b1;
        run("en_back", 12);

        run_until("seek2b", 2, BC + 3);
        digit_en = 4'b0000;
        run("de_zero", 3);
        digit_en = 4'b1111;
        run("de_back", 12);

        run_until("seek1", 1, BC + 1);
        digit_en = 4'b1101;
        run("mid_dis", 12);

        async_reset("rst_pre1");
        digit_en = 4'b1000;
        run("single", 26);

        digit_en = 4'b1111;
        run_until("seek_rst", 2, BC + 2);
        async_reset("rst_mid");
        run("after_rst", 10);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                en       = ($urandom_range(0, 7) != 0);
                digit_en = 4'($urandom);
                dp_in    = 4'($urandom);
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
